dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter that shares the single-port synchronous data memory between two requesters: port A (processor load/store path) and port B (program loader / debug port used by the processor-level benches to preload and inspect memory). Grants at most one access per cycle using round-robin priority. Supports a B-side lock for uninterrupted bursts and returns read data one cycle after grant with a per-port valid strobe. Sits between the datapath's memory stage and the data memory instance.

## Interface
- ADDR_W, 10, word-address width of memory and both ports
- DATA_W, 32, data width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- a_req  in  1  port A requests an access this cycle
- a_we  in  1  port A write enable (1 = store, 0 = load)
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  DATA_W  port A store data
- a_gnt  out  1  port A access issued to memory this cycle
- a_rvalid  out  1  port A read data valid this cycle
- a_rdata  out  DATA_W  port A read data, 0 when a_rvalid = 0
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B
- b_lock  in  1  port B requests exclusive ownership while asserted
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid cycle after a read with m_en = 1

## Operation
- State: mode register (RR, LOCKED), last-granted pointer `last` (A/B), read-return tag register (none/A/B).
- Requester holds req/we/addr/wdata stable until it sees gnt high in the same cycle; gnt is combinational from current req and registered state.
- RR mode: only A requests -> A granted; only B -> B granted; both -> grant the port not equal to `last`. On any grant, `last` updates to the granted port.
- RR -> LOCKED: when B is granted with b_lock = 1.
- LOCKED: A never granted; B granted whenever b_req = 1; remains LOCKED while b_lock = 1. b_lock = 0 in LOCKED -> return to RR next cycle, `last` = B (A wins next contention).
- m_en = a_gnt | b_gnt; m_we/m_addr/m_wdata muxed from the granted port; all 0 when no grant.
- Grant of a read (we = 0) sets return tag to that port; otherwise tag = none. Next cycle: tagged port's rvalid = 1, rdata = m_rdata; untagged port rdata = 0.
- Writes produce no rvalid. Back-to-back reads to either port sustain one access per cycle.

## Timing
- Grant latency: 0 cycles (same cycle as req when selected). Read latency: rvalid exactly 1 cycle after gnt.
- Reset (cycle with reset = 1): a_gnt, b_gnt, m_en, m_we = 0; m_addr, m_wdata = 0; a_rvalid, b_rvalid = 0; rdata outputs 0; after reset mode = RR, `last` = B (A favoured first), tag = none.
- Reset mid-operation: read granted in cycle N, reset in N+1 -> no rvalid in N+1 or later; LOCKED state is abandoned.
- Simultaneous b_lock deassert and b_req in LOCKED: B still granted that cycle (lock checked for next cycle), mode returns to RR.
- b_lock = 1 without b_req in RR: no effect until B is granted.
- Never both gnt high in one cycle; never gnt without corresponding req.

## Test plan
- Reset then single A read addr 0x004 (mem holds 0xFEFE0001) -> a_gnt same cycle, m_addr = 0x004, m_we = 0; next cycle a_rvalid = 1, a_rdata = 0xFEFE0001, b_rvalid = 0.
- A and B both request continuously for 6 cycles after reset -> grants A,B,A,B,A,B; m_addr follows each port's address.
- B write 0x12345678 to 0x010 with b_lock = 1, then 4 cycles of B + A contention with lock held -> only B granted; lock drops -> A granted on next contention cycle.
- A read granted in cycle N, reset asserted N+1 -> a_rvalid stays 0; all outputs 0 during reset; first contention after reset grants A.
- Alternating A read/B read every cycle -> one rvalid per cycle, each tagged to correct port with correct data; writes interleaved produce no rvalid.
- Idle (no req) cycles -> m_en = 0, m_addr = 0, both gnt and rvalid 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between the
// processor load/store port (A) and the loader/debug port (B). At most one
// access is issued per cycle, chosen round-robin, with a B-side lock for
// uninterrupted bursts. Read data returns one cycle after the grant, steered
// to the port that issued the read.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic {MODE_RR, MODE_LOCKED} mode_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_A, TAG_B} tag_t;

  mode_t mode;
  logic  last_b;   // 1 when B was the most recent port granted
  tag_t  tag_p1;   // which port owns the read data arriving this cycle

  // Grant selection: B owns the memory while locked, otherwise round-robin
  // with the port that did not go last winning contention.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      if (mode == MODE_LOCKED) begin
        b_gnt = b_req;
      end else if (a_req && b_req) begin
        a_gnt = last_b;
        b_gnt = !last_b;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Memory command mux from the granted port; all zero when idle.
  always_comb begin
    m_en    = a_gnt | b_gnt;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (a_gnt) begin
      m_we    = a_we;
      m_addr  = a_addr;
      m_wdata = a_wdata;
    end else if (b_gnt) begin
      m_we    = b_we;
      m_addr  = b_addr;
      m_wdata = b_wdata;
    end
  end

  // Read return: reset suppresses any read still in flight.
  assign a_rvalid = !reset && (tag_p1 == TAG_A);
  assign b_rvalid = !reset && (tag_p1 == TAG_B);
  assign a_rdata  = a_rvalid ? m_rdata : '0;
  assign b_rdata  = b_rvalid ? m_rdata : '0;

  // Mode, round-robin pointer and read-return tag update.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode   <= MODE_RR;
      last_b <= 1'b1;
      tag_p1 <= TAG_NONE;
    end else begin
      if (a_gnt) last_b <= 1'b0;
      if (b_gnt) last_b <= 1'b1;

      if (a_gnt && !a_we)      tag_p1 <= TAG_A;
      else if (b_gnt && !b_we) tag_p1 <= TAG_B;
      else                     tag_p1 <= TAG_NONE;

      case (mode)
        MODE_RR: begin
          if (b_gnt && b_lock) mode <= MODE_LOCKED;
        end
        MODE_LOCKED: begin
          // Leaving the lock hands the next contention to A.
          if (!b_lock) begin
            mode   <= MODE_RR;
            last_b <= 1'b1;
          end
        end
        default: mode <= MODE_RR;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural memory behind the
// arbiter, a reference model of the arbitration rules, directed scenarios
// with literal expectations, then randomized traffic.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we, b_lock;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 4) return 32'hFEFE0001;
    return 32'hC0DE0000 ^ DW'(i * 37);
  endfunction

  // Synchronous single-port memory behind the arbiter.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] mem_rd = '0;
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      mem_rd <= mem[m_addr];
    end
  end
  assign m_rdata = mem_rd;

  // Reference model state: what the arbiter must remember between cycles.
  logic [DW-1:0] ref_mem [1024];
  bit            md_locked;
  bit            md_a_went_last;
  int            md_pend;        // 0 none, 1 A, 2 B
  logic [DW-1:0] md_pend_data;

  // Values captured at the sampling edge for directed literal checks.
  logic          ea, eb;
  logic          c_a_gnt, c_b_gnt, c_a_rvalid, c_b_rvalid, c_m_en, c_m_we;
  logic [AW-1:0] c_m_addr;
  logic [DW-1:0] c_a_rdata, c_b_rdata;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model at the
  // falling edge, advance the model, then move past the rising edge.
  task automatic step(input logic r, input logic ar, input logic aw,
                      input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic br, input logic bw,
                      input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic bl);
    logic          x_en, x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wd;
    reset = r; a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
    @(negedge clk);
    if (r) begin
      ea = 1'b0;
      eb = 1'b0;
    end else begin
      ea = ar && !md_locked && (!br || !md_a_went_last);
      eb = br && !ea;
    end
    x_en = ea || eb;
    x_we = ea ? aw : (eb ? bw : 1'b0);
    x_addr = ea ? aa : (eb ? ba : '0);
    x_wd = ea ? ad : (eb ? bd : '0);
    check("a_gnt", DW'(a_gnt), DW'(ea));
    check("b_gnt", DW'(b_gnt), DW'(eb));
    check("m_en", DW'(m_en), DW'(x_en));
    check("m_we", DW'(m_we), DW'(x_we));
    check("m_addr", DW'(m_addr), DW'(x_addr));
    check("m_wdata", m_wdata, x_wd);
    check("a_rvalid", DW'(a_rvalid), DW'(!r && md_pend == 1));
    check("b_rvalid", DW'(b_rvalid), DW'(!r && md_pend == 2));
    check("a_rdata", a_rdata, (!r && md_pend == 1) ? md_pend_data : '0);
    check("b_rdata", b_rdata, (!r && md_pend == 2) ? md_pend_data : '0);
    c_a_gnt = a_gnt; c_b_gnt = b_gnt; c_a_rvalid = a_rvalid; c_b_rvalid = b_rvalid;
    c_a_rdata = a_rdata; c_b_rdata = b_rdata; c_m_en = m_en; c_m_we = m_we;
    c_m_addr = m_addr;
    if (r) begin
      md_locked = 0; md_a_went_last = 0; md_pend = 0;
    end else begin
      md_pend = 0;
      if (x_en) begin
        md_a_went_last = ea;
        if (x_we) ref_mem[x_addr] = x_wd;
        else begin
          md_pend = ea ? 1 : 2;
          md_pend_data = ref_mem[x_addr];
        end
      end
      if (md_locked) begin
        md_locked = bl;
        if (!bl) md_a_went_last = 0;
      end else begin
        md_locked = eb && bl;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    step(r, 0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  logic          ra_req, ra_we, rb_req, rb_we, rb_lock, rr;
  logic [AW-1:0] ra_addr, rb_addr;
  logic [DW-1:0] ra_wd, rb_wd;
  logic [1:0]    gseq;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    md_locked = 0; md_a_went_last = 0; md_pend = 0; md_pend_data = '0;
    @(posedge clk);
    #1;

    // Reset: every output quiet.
    idle(1);
    check("rst_m_en", DW'(c_m_en), 0);
    check("rst_rvalid", DW'({c_a_rvalid, c_b_rvalid}), 0);
    idle(1);

    // Single A read of 0x004.
    step(0, 1, 0, 10'h004, '0, 0, 0, '0, '0, 0);
    check("lit_a_gnt", DW'(c_a_gnt), 1);
    check("lit_m_addr", DW'(c_m_addr), 32'h4);
    check("lit_m_we", DW'(c_m_we), 0);
    idle(0);
    check("lit_a_rvalid", DW'(c_a_rvalid), 1);
    check("lit_a_rdata", c_a_rdata, 32'hFEFE0001);
    check("lit_b_rvalid", DW'(c_b_rvalid), 0);

    // Contention after reset: A,B,A,B,A,B.
    idle(1);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 10'(8 + i), '0, 1, 0, 10'(20 + i), '0, 0);
      gseq = {c_a_gnt, c_b_gnt};
      check("lit_rr_seq", DW'(gseq), (i % 2 == 0) ? 32'd2 : 32'd1);
      check("lit_rr_addr", DW'(c_m_addr), (i % 2 == 0) ? DW'(8 + i) : DW'(20 + i));
    end

    // Locked burst: B write, then 4 contention cycles all to B.
    step(0, 0, 0, '0, '0, 1, 1, 10'h010, 32'h12345678, 1);
    check("lit_lock_wr", DW'(c_b_gnt), 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 10'h030, '0, 1, 0, 10'(i), '0, 1);
      check("lit_locked_b", DW'({c_a_gnt, c_b_gnt}), 32'd1);
    end
    step(0, 1, 0, 10'h030, '0, 1, 0, 10'h010, '0, 0);
    check("lit_unlock_b", DW'({c_a_gnt, c_b_gnt}), 32'd1);
    step(0, 1, 0, 10'h030, '0, 1, 0, 10'h011, '0, 0);
    check("lit_unlock_a", DW'({c_a_gnt, c_b_gnt}), 32'd2);
    check("lit_b_rd_lockwr", c_b_rdata, 32'h12345678);

    // Reset kills an in-flight read; A favoured afterwards.
    step(0, 0, 0, '0, '0, 1, 0, 10'h011, '0, 0);
    step(0, 1, 0, 10'h004, '0, 0, 0, '0, '0, 0);
    idle(1);
    check("lit_rst_rvalid", DW'(c_a_rvalid), 0);
    check("lit_rst_m_en", DW'(c_m_en), 0);
    idle(0);
    check("lit_post_rst_rvalid", DW'(c_a_rvalid), 0);
    step(0, 1, 0, 10'h005, '0, 1, 0, 10'h006, '0, 0);
    check("lit_post_rst_a", DW'({c_a_gnt, c_b_gnt}), 32'd2);

    // Alternating reads with interleaved writes.
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 2)
        step(0, 0, 0, '0, '0, 1, 1, 10'(40 + i), DW'($urandom), 0);
      else if (i % 2 == 0)
        step(0, 1, 0, 10'(40 + i - 1), '0, 0, 0, '0, '0, 0);
      else
        step(0, 0, 0, '0, '0, 1, 0, 10'(40 + i - 2), '0, 0);
    end
    idle(0);
    check("lit_idle_m_en", DW'(c_m_en), 0);
    check("lit_idle_m_addr", DW'(c_m_addr), 0);

    // Randomized traffic; requesters hold their request until granted.
    ra_req = 0; rb_req = 0; rb_lock = 0;
    ra_we = 0; rb_we = 0; ra_addr = '0; rb_addr = '0; ra_wd = '0; rb_wd = '0;
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom % 60 == 0);
      if (!ra_req && ($urandom % 3 != 0)) begin
        ra_req = 1; ra_we = 1'($urandom); ra_addr = 10'($urandom % 16); ra_wd = $urandom;
      end
      if (!rb_req && ($urandom % 3 != 0)) begin
        rb_req = 1; rb_we = 1'($urandom); rb_addr = 10'($urandom % 16); rb_wd = $urandom;
      end
      if ($urandom % 5 == 0) rb_lock = !rb_lock;
      step(rr, ra_req, ra_we, ra_addr, ra_wd, rb_req, rb_we, rb_addr, rb_wd, rb_lock);
      if (ea || rr) ra_req = 0;
      if (eb || rr) rb_req = 0;
    end
    idle(0);
    idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
